// File: rtl/mips_pkg.sv
// mips_pkg
//   Shared definitions for the MIPS front end: default bus widths, the
//   bubble instruction and the fetch FSM state encodings.
//   No ports (package).
package mips_pkg;

  localparam int AW_DEFAULT = 32;
  localparam int DW_DEFAULT = 32;

  // Instruction presented on IF/ID whenever it does not hold a real one.
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  // Fetch FSM states, kept as plain constants for compatibility with older tools.
  localparam logic [1:0] FETCH  = 2'd0;
  localparam logic [1:0] BUFFER = 2'd1;
  localparam logic [1:0] DROP   = 2'd2;

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if
//   Instruction memory request/acknowledge bus.
//   req   : fetch request, driven by the fetch stage
//   addr  : fetch address, held stable while req=1 until ack
//   ack   : rdata valid this cycle; ends the request
//   rdata : fetched instruction
//   master modport = fetch stage side, slave modport = memory side.
interface fetch_stage_if
  import mips_pkg::*;
#(
  parameter int AW = AW_DEFAULT,
  parameter int DW = DW_DEFAULT
) ();

  logic          req;
  logic [AW-1:0] addr;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);

endinterface

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf
//   One-entry holding register for an instruction that arrived while ID
//   was stalled.
//   clk, reset          : clock, synchronous active-high reset
//   load                : capture {in_instr, in_pc, in_pc4}, mark full
//   clear               : mark empty (wins over load)
//   in_instr/in_pc/in_pc4 : entry to capture
//   full                : entry is valid
//   instr/pc/pc4        : stored entry
module fetch_skid_buf #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          clear,
  input  logic [DW-1:0] in_instr,
  input  logic [AW-1:0] in_pc,
  input  logic [AW-1:0] in_pc4,
  output logic          full,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] pc4
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end
  end

  // Payload needs no reset: it is only consumed while full=1.
  always_ff @(posedge clk) begin
    if (load) begin
      instr <= in_instr;
      pc    <= in_pc;
      pc4   <= in_pc4;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
//   IF stage: fetches the instruction at pc over the imem handshake, loads
//   the IF/ID register, drives the PC register enable, absorbs ID stalls in
//   a one-entry skid buffer and discards wrong-path fetches on flush.
//   clk, reset    : clock, synchronous active-high reset
//   pc            : current PC from the PC register
//   pc_enable     : advance the PC register this cycle
//   stall_id      : ID must hold its instruction
//   flush         : EX redirect; next-PC mux selects the target this cycle
//   imem          : instruction memory bus (master side)
//   if_id_valid   : IF/ID holds a real instruction
//   if_id_instr   : IF/ID instruction (NOP_INSTR while invalid)
//   if_id_pc      : IF/ID instruction address
//   if_id_pc4     : IF/ID pc+4, wrapping modulo 2^AW
module fetch_stage
  import mips_pkg::*;
#(
  parameter int            AW        = AW_DEFAULT,
  parameter int            DW        = DW_DEFAULT,
  parameter logic [DW-1:0] NOP_INSTR = DW'(NOP_INSTR_DEFAULT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] pc,
  output logic          pc_enable,
  input  logic          stall_id,
  input  logic          flush,
  fetch_stage_if.master imem,
  output logic          if_id_valid,
  output logic [DW-1:0] if_id_instr,
  output logic [AW-1:0] if_id_pc,
  output logic [AW-1:0] if_id_pc4
);

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [AW-1:0] drop_addr;
  logic          drop_latch;
  logic          req_c;
  logic [AW-1:0] addr_c;
  logic          space;
  logic [AW-1:0] pc4;
  logic          skid_load;
  logic          skid_clear;
  logic          skid_full;
  logic [DW-1:0] skid_instr;
  logic [AW-1:0] skid_pc;
  logic [AW-1:0] skid_pc4;
  logic          skid_to_if_id;

  assign space = !if_id_valid || !stall_id;
  assign pc4   = pc + AW'(4);

  assign imem.req  = req_c;
  assign imem.addr = addr_c;

  assign skid_to_if_id = (state == BUFFER) && !stall_id && skid_full;

  // Next-state and handshake decode. Flush is checked first in every state.
  // The PC is advanced exactly once per fetched instruction: at the ack in
  // FETCH, never again when the skid drains.
  always_comb begin
    state_next = state;
    req_c      = 1'b0;
    addr_c     = pc;
    pc_enable  = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    drop_latch = 1'b0;
    case (state)
      FETCH: begin
        req_c = 1'b1;
        if (flush) begin
          pc_enable = 1'b1;
          if (!imem.ack) begin
            drop_latch = 1'b1;
            state_next = DROP;
          end
        end else if (imem.ack) begin
          pc_enable = 1'b1;
          if (!space) begin
            skid_load  = 1'b1;
            state_next = BUFFER;
          end
        end
      end
      BUFFER: begin
        if (flush) begin
          skid_clear = 1'b1;
          pc_enable  = 1'b1;
          state_next = FETCH;
        end else if (!stall_id) begin
          skid_clear = 1'b1;
          state_next = FETCH;
        end
      end
      DROP: begin
        // Keep the abandoned request alive on its original address until
        // the memory acks it, then throw the data away.
        req_c  = 1'b1;
        addr_c = drop_addr;
        if (flush) begin
          pc_enable = 1'b1;
        end else if (imem.ack) begin
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
    if (reset) begin
      req_c     = 1'b0;
      pc_enable = 1'b0;
    end
  end

  // FSM state and the address of the request being dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      drop_addr <= '0;
    end else begin
      state <= state_next;
      if (drop_latch) begin
        drop_addr <= pc;
      end
    end
  end

  // IF/ID register. The instruction field is forced to NOP whenever the
  // entry is invalidated so ID never sees stale bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
      if_id_pc    <= '0;
      if_id_pc4   <= '0;
    end else if (flush) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
    end else if (stall_id && if_id_valid) begin
      if_id_valid <= if_id_valid;
    end else if (skid_to_if_id) begin
      if_id_valid <= 1'b1;
      if_id_instr <= skid_instr;
      if_id_pc    <= skid_pc;
      if_id_pc4   <= skid_pc4;
    end else if ((state == FETCH) && imem.ack) begin
      if_id_valid <= 1'b1;
      if_id_instr <= imem.rdata;
      if_id_pc    <= pc;
      if_id_pc4   <= pc4;
    end else begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
    end
  end

  fetch_skid_buf #(.AW(AW), .DW(DW)) u_skid (
    .clk      (clk),
    .reset    (reset),
    .load     (skid_load),
    .clear    (skid_clear),
    .in_instr (imem.rdata),
    .in_pc    (pc),
    .in_pc4   (pc4),
    .full     (skid_full),
    .instr    (skid_instr),
    .pc       (skid_pc),
    .pc4      (skid_pc4)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
//   Directed bench for fetch_stage. A small PC register model follows
//   pc_enable/flush; memory ack/rdata are driven step by step.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        pc_enable;
  logic        stall_id;
  logic        flush;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;

  logic        set_pc_req;
  logic [31:0] set_pc_val;
  logic [31:0] flush_target;

  int n_asserts;
  int n_fails;

  fetch_stage_if #(.AW(32), .DW(32)) imem ();

  fetch_stage #(.AW(32), .DW(32), .NOP_INSTR(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .pc_enable   (pc_enable),
    .stall_id    (stall_id),
    .flush       (flush),
    .imem        (imem),
    .if_id_valid (if_id_valid),
    .if_id_instr (if_id_instr),
    .if_id_pc    (if_id_pc),
    .if_id_pc4   (if_id_pc4)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // PC register model: a direct load from the bench wins, then reset,
  // then the enable with the next-PC mux (target on flush, else pc+4).
  always @(posedge clk) begin
    if (set_pc_req) begin
      pc <= set_pc_val;
    end else if (reset) begin
      pc <= 32'h0;
    end else if (pc_enable) begin
      pc <= flush ? flush_target : pc + 32'd4;
    end
  end

  // Drive one cycle's inputs just after the falling edge, then let the
  // combinational outputs settle before any checks.
  task automatic applyStimulus(input logic rst, input logic stall, input logic fl,
                               input logic ack, input logic [31:0] rdata,
                               input logic setpc, input logic [31:0] pcval,
                               input logic [31:0] target);
    @(negedge clk);
    reset        = rst;
    stall_id     = stall;
    flush        = fl;
    imem.ack     = ack;
    imem.rdata   = rdata;
    set_pc_req   = setpc;
    set_pc_val   = pcval;
    flush_target = target;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_asserts    = 0;
    n_fails      = 0;
    reset        = 1'b1;
    stall_id     = 1'b0;
    flush        = 1'b0;
    imem.ack     = 1'b0;
    imem.rdata   = 32'h0;
    set_pc_req   = 1'b0;
    set_pc_val   = 32'h0;
    flush_target = 32'h0;

    $display("[TB] reset");
    applyStimulus(1, 0, 0, 1, 32'hAAAA_AAAA, 0, 0, 0);
    checkOutput("rst_req",   32'(imem.req),    32'h0);
    checkOutput("rst_pcen",  32'(pc_enable),   32'h0);
    checkOutput("rst_valid", 32'(if_id_valid), 32'h0);
    checkOutput("rst_instr", if_id_instr,      32'h0);
    checkOutput("rst_pc",    if_id_pc,         32'h0);
    checkOutput("rst_pc4",   if_id_pc4,        32'h0);

    $display("[TB] zero-wait stream");
    applyStimulus(0, 0, 0, 1, 32'h1111_0000, 0, 0, 0);
    checkOutput("zw_req0",  32'(imem.req),  32'h1);
    checkOutput("zw_addr0", imem.addr,      32'h0);
    checkOutput("zw_pcen0", 32'(pc_enable), 32'h1);
    applyStimulus(0, 0, 0, 1, 32'h1111_0004, 0, 0, 0);
    checkOutput("zw_valid0", 32'(if_id_valid), 32'h1);
    checkOutput("zw_pc0",    if_id_pc,         32'h0);
    checkOutput("zw_instr0", if_id_instr,      32'h1111_0000);
    checkOutput("zw_pc4_0",  if_id_pc4,        32'h4);
    checkOutput("zw_addr1",  imem.addr,        32'h4);
    checkOutput("zw_pcen1",  32'(pc_enable),   32'h1);
    applyStimulus(0, 0, 0, 1, 32'h1111_0008, 0, 0, 0);
    checkOutput("zw_pc1",    if_id_pc,         32'h4);
    checkOutput("zw_instr1", if_id_instr,      32'h1111_0004);
    checkOutput("zw_addr2",  imem.addr,        32'h8);
    checkOutput("zw_pcen2",  32'(pc_enable),   32'h1);
    applyStimulus(0, 0, 0, 0, 32'h0, 1, 32'h10, 0);
    checkOutput("zw_valid2", 32'(if_id_valid), 32'h1);
    checkOutput("zw_pc2",    if_id_pc,         32'h8);
    checkOutput("zw_instr2", if_id_instr,      32'h1111_0008);
    checkOutput("zw_pcen3",  32'(pc_enable),   32'h0);

    $display("[TB] multi-cycle ack at 0x10");
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 0, 0);
    checkOutput("mc_bubble", 32'(if_id_valid), 32'h0);
    checkOutput("mc_nop",    if_id_instr,      32'h0);
    checkOutput("mc_addr0",  imem.addr,        32'h10);
    checkOutput("mc_pcen0",  32'(pc_enable),   32'h0);
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 0, 0);
    checkOutput("mc_addr1",  imem.addr,        32'h10);
    checkOutput("mc_req1",   32'(imem.req),    32'h1);
    checkOutput("mc_pcen1",  32'(pc_enable),   32'h0);
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 0, 0);
    checkOutput("mc_addr2",  imem.addr,        32'h10);
    checkOutput("mc_pcen2",  32'(pc_enable),   32'h0);
    applyStimulus(0, 0, 0, 1, 32'h2222_0010, 0, 0, 0);
    checkOutput("mc_addr3",  imem.addr,        32'h10);
    checkOutput("mc_pcen3",  32'(pc_enable),   32'h1);

    $display("[TB] stall with skid at 0x20");
    applyStimulus(0, 1, 0, 0, 32'h0, 1, 32'h20, 0);
    checkOutput("mc_valid",  32'(if_id_valid), 32'h1);
    checkOutput("mc_pc",     if_id_pc,         32'h10);
    checkOutput("mc_instr",  if_id_instr,      32'h2222_0010);
    checkOutput("mc_pc4",    if_id_pc4,        32'h14);
    checkOutput("mc_pcen4",  32'(pc_enable),   32'h0);
    applyStimulus(0, 1, 0, 1, 32'h3333_0020, 0, 0, 0);
    checkOutput("sk_addr",   imem.addr,        32'h20);
    checkOutput("sk_pcen",   32'(pc_enable),   32'h1);
    checkOutput("sk_hold0",  if_id_pc,         32'h10);
    applyStimulus(0, 1, 0, 0, 32'h0, 0, 0, 0);
    checkOutput("sk_req0",   32'(imem.req),    32'h0);
    checkOutput("sk_pcen0",  32'(pc_enable),   32'h0);
    checkOutput("sk_hold1",  if_id_pc,         32'h10);
    checkOutput("sk_valid1", 32'(if_id_valid), 32'h1);
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 0, 0);
    checkOutput("sk_req1",   32'(imem.req),    32'h0);
    checkOutput("sk_pcen1",  32'(pc_enable),   32'h0);
    checkOutput("sk_hold2",  if_id_pc,         32'h10);
    applyStimulus(0, 0, 0, 0, 32'h0, 1, 32'h30, 0);
    checkOutput("sk_valid",  32'(if_id_valid), 32'h1);
    checkOutput("sk_pc",     if_id_pc,         32'h20);
    checkOutput("sk_instr",  if_id_instr,      32'h3333_0020);
    checkOutput("sk_pc4",    if_id_pc4,        32'h24);
    checkOutput("sk_addr2",  imem.addr,        32'h24);
    checkOutput("sk_req2",   32'(imem.req),    32'h1);

    $display("[TB] flush while waiting at 0x30");
    applyStimulus(0, 0, 1, 0, 32'h0, 0, 0, 32'h40);
    checkOutput("sk_once",   32'(if_id_valid), 32'h0);
    checkOutput("fl_addr0",  imem.addr,        32'h30);
    checkOutput("fl_pcen0",  32'(pc_enable),   32'h1);
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 0, 0);
    checkOutput("fl_addr1",  imem.addr,        32'h30);
    checkOutput("fl_req1",   32'(imem.req),    32'h1);
    checkOutput("fl_pcen1",  32'(pc_enable),   32'h0);
    checkOutput("fl_valid1", 32'(if_id_valid), 32'h0);
    applyStimulus(0, 0, 0, 1, 32'hDEAD_0030, 0, 0, 0);
    checkOutput("fl_addr2",  imem.addr,        32'h30);
    checkOutput("fl_pcen2",  32'(pc_enable),   32'h0);
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 0, 0);
    checkOutput("fl_valid3", 32'(if_id_valid), 32'h0);
    checkOutput("fl_instr3", if_id_instr,      32'h0);
    checkOutput("fl_addr3",  imem.addr,        32'h40);
    checkOutput("fl_req3",   32'(imem.req),    32'h1);

    $display("[TB] flush and stall in BUFFER");
    applyStimulus(0, 0, 0, 1, 32'h4444_0040, 0, 0, 0);
    checkOutput("fb_pcen0",  32'(pc_enable),   32'h1);
    applyStimulus(0, 1, 0, 1, 32'h4444_0044, 0, 0, 0);
    checkOutput("fb_pc0",    if_id_pc,         32'h40);
    checkOutput("fb_addr1",  imem.addr,        32'h44);
    checkOutput("fb_pcen1",  32'(pc_enable),   32'h1);
    applyStimulus(0, 1, 1, 0, 32'h0, 0, 0, 32'h80);
    checkOutput("fb_req2",   32'(imem.req),    32'h0);
    checkOutput("fb_pcen2",  32'(pc_enable),   32'h1);
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 0, 0);
    checkOutput("fb_valid3", 32'(if_id_valid), 32'h0);
    checkOutput("fb_instr3", if_id_instr,      32'h0);
    checkOutput("fb_addr3",  imem.addr,        32'h80);
    checkOutput("fb_req3",   32'(imem.req),    32'h1);
    applyStimulus(0, 0, 0, 0, 32'h0, 1, 32'hFFFF_FFFC, 0);
    checkOutput("fb_valid4", 32'(if_id_valid), 32'h0);

    $display("[TB] pc wrap and reset in DROP");
    applyStimulus(0, 0, 0, 1, 32'h5555_FFFC, 0, 0, 0);
    checkOutput("wr_addr",   imem.addr,        32'hFFFF_FFFC);
    applyStimulus(0, 0, 1, 0, 32'h0, 0, 0, 32'h100);
    checkOutput("wr_valid",  32'(if_id_valid), 32'h1);
    checkOutput("wr_pc",     if_id_pc,         32'hFFFF_FFFC);
    checkOutput("wr_pc4",    if_id_pc4,        32'h0);
    checkOutput("wr_addr1",  imem.addr,        32'h0);
    applyStimulus(1, 0, 0, 0, 32'h0, 1, 32'h200, 0);
    checkOutput("rd_req",    32'(imem.req),    32'h0);
    checkOutput("rd_pcen",   32'(pc_enable),   32'h0);
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 0, 0);
    checkOutput("rd_valid",  32'(if_id_valid), 32'h0);
    checkOutput("rd_instr",  if_id_instr,      32'h0);
    checkOutput("rd_addr",   imem.addr,        32'h200);
    checkOutput("rd_req1",   32'(imem.req),    32'h1);
    applyStimulus(0, 0, 0, 1, 32'h6666_0200, 0, 0, 0);
    checkOutput("rd_pcen1",  32'(pc_enable),   32'h1);
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 0, 0);
    checkOutput("rd_valid2", 32'(if_id_valid), 32'h1);
    checkOutput("rd_pc2",    if_id_pc,         32'h200);
    checkOutput("rd_instr2", if_id_instr,      32'h6666_0200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
